// File: rtl/button_debounce_reader.sv
// Per-channel synchroniser, debouncer and press/release/long-press FSM for active-low push-buttons.
// Outputs btn_state plus one-cycle registered press, release and long-press pulses.
module button_debounce_reader #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_PRESSED  = 2'd1,
    S_LONG     = 2'd2
  } state_e;

  logic [NUM_BTN-1:0] sync1_q, sync2_q, raw;
  logic [NUM_BTN-1:0] accept;
  logic [DW-1:0]      db_cnt_q [NUM_BTN];
  logic [DW-1:0]      db_cnt_d [NUM_BTN];
  logic [LW-1:0]      hold_q   [NUM_BTN];
  logic [LW-1:0]      hold_d   [NUM_BTN];
  state_e             state_q  [NUM_BTN];
  state_e             state_d  [NUM_BTN];
  logic [NUM_BTN-1:0] press_q, press_d, rel_q, rel_d, long_q, long_d;

  assign raw           = ~sync2_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;

  always_comb begin
    btn_state = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      btn_state[i] = (state_q[i] != S_RELEASED);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Sync flops reset to "released" so a held button is seen as a fresh press.
      sync1_q <= '1;
      sync2_q <= '1;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= '0;
        hold_q[i]   <= '0;
        state_q[i]  <= S_RELEASED;
      end
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        hold_q[i]   <= hold_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  always_comb begin
    accept  = '0;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      hold_d[i]   = hold_q[i];
      state_d[i]  = state_q[i];

      // A disagreeing sample must persist DEBOUNCE_CYCLES edges; any agreement restarts the count.
      if (raw[i] != btn_state[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          accept[i] = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      case (state_q[i])
        S_RELEASED: begin
          if (accept[i]) begin
            state_d[i] = S_PRESSED;
            press_d[i] = 1'b1;
            hold_d[i]  = '0;
          end
        end
        S_PRESSED: begin
          // Release outranks a long-press completing on the same edge.
          if (accept[i]) begin
            state_d[i] = S_RELEASED;
            rel_d[i]   = 1'b1;
          end else if (hold_q[i] == HOLD_LAST) begin
            state_d[i] = S_LONG;
            long_d[i]  = 1'b1;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end
        S_LONG: begin
          if (accept[i]) begin
            state_d[i] = S_RELEASED;
            rel_d[i]   = 1'b1;
          end
        end
        default: state_d[i] = S_RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce_reader.sv
// Bench for button_debounce_reader: segment table plus hand sequences; expected pulses are
// scheduled in a scoreboard at drive time and matched cycle by cycle at the falling edge.
module tb_button_debounce_reader;

  localparam int unsigned NB   = 2;
  localparam int          DB   = 4;
  localparam int          LG   = 20;
  localparam int          LAT  = 2 + DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] btn_state, press_pulse, release_pulse, long_pulse;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    int ch;
    int kind;  // 0 press, 1 release, 2 long
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic          rst;
    logic [NB-1:0] btn_n;
    int            cycles;
    logic [NB-1:0] exp_state;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] lng;
  } vec_t;

  button_debounce_reader #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .btn_state    (btn_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_mask(input int at, input logic [NB-1:0] m, input int kind);
    ev_t e;
    for (int c = 0; c < int'(NB); c++) begin
      if (m[c]) begin
        e.cyc = at; e.ch = c; e.kind = kind;
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_cycle();
    logic act, exp;
    string nm;
    for (int c = 0; c < int'(NB); c++) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin act = press_pulse[c];   nm = "press";   end
          1: begin act = release_pulse[c]; nm = "release"; end
          default: begin act = long_pulse[c]; nm = "long"; end
        endcase
        exp = 1'b0;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].cyc == cyc && sb[j].ch == c && sb[j].kind == k) begin
            exp = 1'b1;
            sb.delete(j);
            break;
          end
        end
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL %s_pulse[%0d] cyc=%0d got=%b exp=%b", nm, c, cyc, act, exp);
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [NB-1:0] b, input int n);
    rst   = r;
    btn_n = b;
    repeat (n) begin
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic check_state(input logic [NB-1:0] exp, input string nm);
    n_checks++;
    if (btn_state !== exp) begin
      n_fail++;
      $display("FAIL %s btn_state cyc=%0d got=%b exp=%b", nm, cyc, btn_state, exp);
    end
  endtask

  vec_t vecs[8];

  initial begin
    //         rst   btn_n  cyc state  prs    rel    lng
    vecs[0] = '{1'b1, 2'b11, 3,  2'b00, 2'b00, 2'b00, 2'b00};  // reset
    vecs[1] = '{1'b0, 2'b11, 50, 2'b00, 2'b00, 2'b00, 2'b00};  // idle
    vecs[2] = '{1'b0, 2'b10, 10, 2'b01, 2'b01, 2'b00, 2'b00};  // clean press ch0
    vecs[3] = '{1'b0, 2'b11, 10, 2'b00, 2'b00, 2'b01, 2'b00};
    vecs[4] = '{1'b0, 2'b01, 40, 2'b10, 2'b10, 2'b00, 2'b10};  // long press ch1
    vecs[5] = '{1'b0, 2'b11, 12, 2'b00, 2'b00, 2'b10, 2'b00};
    vecs[6] = '{1'b0, 2'b10, 15, 2'b01, 2'b01, 2'b00, 2'b00};  // short press ch0
    vecs[7] = '{1'b0, 2'b11, 30, 2'b00, 2'b00, 2'b01, 2'b00};

    for (int v = 0; v < 8; v++) begin
      push_mask(cyc + LAT, vecs[v].prs, 0);
      push_mask(cyc + LAT, vecs[v].rel, 1);
      push_mask(cyc + LAT + LG, vecs[v].lng, 2);
      drive(vecs[v].rst, vecs[v].btn_n, vecs[v].cycles);
      check_state(vecs[v].exp_state, $sformatf("vec%0d", v));
    end

    // Bounce: 3-cycle lows never qualify; press lands LAT after the final falling edge.
    drive(1'b0, 2'b10, 3);
    drive(1'b0, 2'b11, 1);
    drive(1'b0, 2'b10, 3);
    drive(1'b0, 2'b11, 1);
    check_state(2'b00, "bounce_no_press");
    push_mask(cyc + LAT, 2'b01, 0);
    drive(1'b0, 2'b10, 12);
    check_state(2'b01, "bounce_press");
    push_mask(cyc + LAT, 2'b01, 1);
    drive(1'b0, 2'b11, 12);
    check_state(2'b00, "bounce_release");

    // Reset mid-hold with the button still low.
    push_mask(cyc + LAT, 2'b01, 0);
    drive(1'b0, 2'b10, 10);
    check_state(2'b01, "prehold");
    drive(1'b1, 2'b10, 1);
    check_state(2'b00, "in_reset");
    push_mask(cyc + LAT, 2'b01, 0);
    drive(1'b0, 2'b10, 10);
    check_state(2'b01, "post_reset_press");
    push_mask(cyc + LAT, 2'b01, 1);
    drive(1'b0, 2'b11, 12);
    check_state(2'b00, "post_reset_release");

    // Simultaneous presses on both channels.
    push_mask(cyc + LAT, 2'b11, 0);
    drive(1'b0, 2'b00, 10);
    check_state(2'b11, "dual_press");
    push_mask(cyc + LAT, 2'b11, 1);
    drive(1'b0, 2'b11, 12);
    check_state(2'b00, "dual_release");

    drive(1'b0, 2'b11, 5);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
